// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
//   Bundles the display controller's data-side inputs and pin-side outputs.
//   master: the producer/observer (drives the numbers, sees the pins).
//   slave : the controller itself.
//   Signals: en, digits, dp_in, lz_en, brightness (to controller);
//            pos, dout, dp, frame_start (from controller).
interface seg7_scan_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   digits;
    logic [DIGITS-1:0]     dp_in;
    logic                  lz_en;
    logic [3:0]            brightness;
    logic [DIGITS-1:0]     pos;
    logic [6:0]            dout;
    logic                  dp;
    logic                  frame_start;

    modport master (
        output en, digits, dp_in, lz_en, brightness,
        input  pos, dout, dp, frame_start
    );

    modport slave (
        input  en, digits, dp_in, lz_en, brightness,
        output pos, dout, dp, frame_start
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed common-anode seven-segment controller with blanking,
//   PWM brightness, leading-zero suppression and a per-frame input snapshot.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - seg7_scan_ctrl_if.slave (inputs: en, digits, dp_in, lz_en,
//            brightness; registered outputs: pos, dout, dp, frame_start)
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned TICK_DIV     = 50_000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input logic             clk,
    input logic             rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int unsigned SlotW = $clog2(TICK_DIV);
    localparam int unsigned IdxW  = $clog2(DIGITS);
    localparam logic [SlotW-1:0] SlotLast = SlotW'(TICK_DIV - 1);
    localparam logic [SlotW-1:0] BlankEnd = SlotW'(BLANK_CYCLES);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DIGITS - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [SlotW-1:0]    slot_q, slot_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [3:0]          pwm_q, pwm_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [DIGITS-1:0]   dpin_q, dpin_d;
    logic                lz_q, lz_d;
    logic [3:0]          bright_q, bright_d;
    logic [DIGITS-1:0]   pos_q, pos_d;
    logic [6:0]          dout_q, dout_d;
    logic                dp_q, dp_d;
    logic                fs_q;

    logic                snap;
    logic                lit;
    logic                zero_above;
    logic [DIGITS-1:0]   supp;
    logic [3:0]          nib [DIGITS];

    // Counters and snapshot capture
    always_comb begin
        slot_d   = slot_q;
        idx_d    = idx_q;
        pwm_d    = pwm_q;
        snap     = bus.en && (idx_q == '0) && (slot_q == '0);
        digits_d = snap ? bus.digits     : digits_q;
        dpin_d   = snap ? bus.dp_in      : dpin_q;
        lz_d     = snap ? bus.lz_en      : lz_q;
        bright_d = snap ? bus.brightness : bright_q;
        if (bus.en) begin
            pwm_d = pwm_q + 4'd1;
            if (slot_q == SlotLast) begin
                slot_d = '0;
                idx_d  = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end
    end

    // Suppression walks from the most significant digit down: a digit is
    // blanked while every nibble at or above it is zero. Digit 0 never is.
    always_comb begin
        zero_above = 1'b1;
        supp       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib[i] = digits_q[4*i +: 4];
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (nib[i] == 4'h0);
            if (i > 0) begin
                supp[i] = lz_q && zero_above;
            end
        end
    end

    // Output decode from the current counter state; registered below.
    // The snapshot slot is always blank, so using the old shadow there is harmless.
    always_comb begin
        lit    = (slot_q >= BlankEnd) && (pwm_q <= bright_q) && !supp[idx_q];
        pos_d  = '1;
        dout_d = 7'h7F;
        dp_d   = 1'b1;
        if (bus.en && lit) begin
            pos_d[idx_q] = 1'b0;
            dout_d       = hex7(nib[idx_q]);
            dp_d         = ~dpin_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= '0;
            idx_q    <= '0;
            pwm_q    <= '0;
            digits_q <= '0;
            dpin_q   <= '0;
            lz_q     <= 1'b0;
            bright_q <= '0;
            pos_q    <= '1;
            dout_q   <= 7'h7F;
            dp_q     <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            idx_q    <= idx_d;
            pwm_q    <= pwm_d;
            digits_q <= digits_d;
            dpin_q   <= dpin_d;
            lz_q     <= lz_d;
            bright_q <= bright_d;
            pos_q    <= pos_d;
            dout_q   <= dout_d;
            dp_q     <= dp_d;
            fs_q     <= snap;
        end
    end

    assign bus.pos         = pos_q;
    assign bus.dout        = dout_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = fs_q;
endmodule
